// File: rtl/bnn_dense_layer.sv
// Binary dense layer: XNOR-popcount per CHUNK bits, threshold per neuron; CALC = N_OUT*NCH+1 cycles.
// Latency N_OUT*NCH+1 cycles from rcv_ack; result held in SND_WAIT/SND until downstream releases snd_req.
module bnn_dense_layer #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 256,
    parameter int CHUNK = 16,
    localparam int NCH  = N_IN / CHUNK,
    localparam int CW   = $clog2(N_IN + 1),
    localparam int AW   = $clog2(N_OUT * NCH)
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic [N_IN-1:0]  inputs,
    input  logic             rcv_ack,
    output logic             rcv_req,
    output logic [AW-1:0]    w_addr,
    input  logic [CHUNK-1:0] w_data,
    input  logic [CW-1:0]    thr_data,
    input  logic             snd_req,
    output logic             snd_ack,
    output logic [N_OUT-1:0] outputs,
    output logic             busy
);
    localparam int TOT = N_OUT * NCH;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CALC     = 2'd1;
    localparam logic [1:0] S_SND_WAIT = 2'd2;
    localparam logic [1:0] S_SND      = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [N_IN-1:0]  x_q, x_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             issue_q, issue_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic             pvld_q, pvld_d;
    logic [JW-1:0]    pj_q, pj_d;
    logic [KW-1:0]    pk_q, pk_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [N_OUT-1:0] outputs_q, outputs_d;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] match;
    logic [CW-1:0]    pc;
    logic [CW-1:0]    acc_sum;
    logic             last_chunk;
    logic             last_neuron;

    // pk_q/pj_q describe the chunk whose weights arrive this cycle (address issued last cycle)
    always_comb begin
        x_chunk = x_q[int'(pk_q) * CHUNK +: CHUNK];
        match   = ~(x_chunk ^ w_data);
        pc      = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + CW'(match[i]);
        end
        acc_sum     = ((pk_q == '0) ? '0 : acc_q) + pc;
        last_chunk  = (pk_q == KW'(NCH - 1));
        last_neuron = (pj_q == JW'(N_OUT - 1));
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        addr_d    = addr_q;
        issue_d   = issue_q;
        j_d       = j_q;
        k_d       = k_q;
        pvld_d    = 1'b0;
        pj_d      = pj_q;
        pk_d      = pk_q;
        acc_d     = acc_q;
        outputs_d = outputs_q;
        case (state_q)
            S_IDLE: begin
                if (rcv_ack) begin
                    x_d     = inputs;
                    state_d = S_CALC;
                    addr_d  = '0;
                    issue_d = 1'b1;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_CALC: begin
                if (issue_q) begin
                    pvld_d = 1'b1;
                    pj_d   = j_q;
                    pk_d   = k_q;
                    addr_d = addr_q + AW'(1);
                    if (k_q == KW'(NCH - 1)) begin
                        k_d = '0;
                        j_d = j_q + JW'(1);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                    if (addr_q == AW'(TOT - 1)) begin
                        issue_d = 1'b0;
                    end
                end
                if (pvld_q) begin
                    acc_d = acc_sum;
                    if (last_chunk) begin
                        outputs_d[pj_q] = (acc_sum >= thr_data);
                        if (last_neuron) begin
                            state_d = S_SND_WAIT;
                        end
                    end
                end
            end
            S_SND_WAIT: begin
                if (snd_req) begin
                    state_d = S_SND;
                end
            end
            default: begin
                if (!snd_req) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            addr_q    <= '0;
            issue_q   <= 1'b0;
            j_q       <= '0;
            k_q       <= '0;
            pvld_q    <= 1'b0;
            pj_q      <= '0;
            pk_q      <= '0;
            acc_q     <= '0;
            outputs_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            addr_q    <= addr_d;
            issue_q   <= issue_d;
            j_q       <= j_d;
            k_q       <= k_d;
            pvld_q    <= pvld_d;
            pj_q      <= pj_d;
            pk_q      <= pk_d;
            acc_q     <= acc_d;
            outputs_q <= outputs_d;
        end
    end

    assign rcv_req = (state_q == S_IDLE);
    assign snd_ack = (state_q == S_SND);
    assign busy    = (state_q == S_CALC);
    assign w_addr  = (busy && issue_q) ? addr_q : '0;
    assign outputs = outputs_q;

endmodule

// File: tb/tb_bnn_dense_layer.sv
// Scoreboarded bench for bnn_dense_layer: per-bit match-count reference model, synchronous ROM model.
module tb_bnn_dense_layer;
    localparam int N_IN  = 8;
    localparam int N_OUT = 4;
    localparam int CHUNK = 4;
    localparam int NCH   = N_IN / CHUNK;
    localparam int CW    = $clog2(N_IN + 1);
    localparam int AW    = $clog2(N_OUT * NCH);
    localparam int TOT   = N_OUT * NCH;

    logic             clk = 1'b0;
    logic             xrst;
    logic [N_IN-1:0]  inputs;
    logic             rcv_ack;
    logic             rcv_req;
    logic [AW-1:0]    w_addr;
    logic [CHUNK-1:0] w_data = '0;
    logic [CW-1:0]    thr_data = '0;
    logic             snd_req;
    logic             snd_ack;
    logic [N_OUT-1:0] outputs;
    logic             busy;

    int errors = 0;
    int checks = 0;

    logic [N_IN-1:0]  wvec [N_OUT];
    int               thr_tab [N_OUT];
    logic [N_OUT-1:0] exp_q [$];

    always #5 clk = ~clk;

    bnn_dense_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK)) dut (
        .clk(clk), .xrst(xrst), .inputs(inputs), .rcv_ack(rcv_ack), .rcv_req(rcv_req),
        .w_addr(w_addr), .w_data(w_data), .thr_data(thr_data), .snd_req(snd_req),
        .snd_ack(snd_ack), .outputs(outputs), .busy(busy)
    );

    // One-cycle synchronous weight/threshold ROM
    always @(posedge clk) begin
        w_data   <= wvec[int'(w_addr) / NCH][(int'(w_addr) % NCH) * CHUNK +: CHUNK];
        thr_data <= CW'(thr_tab[int'(w_addr) / NCH]);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N_OUT-1:0] golden(input logic [N_IN-1:0] x);
        logic [N_OUT-1:0] g;
        int cnt;
        for (int j = 0; j < N_OUT; j++) begin
            cnt = 0;
            for (int i = 0; i < N_IN; i++) begin
                if (x[i] == wvec[j][i]) cnt++;
            end
            g[j] = (cnt >= thr_tab[j]);
        end
        return g;
    endfunction

    task automatic randomize_tables();
        for (int j = 0; j < N_OUT; j++) begin
            wvec[j]    = N_IN'($urandom);
            thr_tab[j] = $urandom_range(0, N_IN + 1);
        end
    endtask

    // Monitor: CALC length, address sweep, held bits, and scoreboard pop on SND entry
    int               busy_cnt = 0;
    logic             prev_ack = 1'b0;
    logic [N_OUT-1:0] last_out = '0;
    logic [N_OUT-1:0] e;

    always @(negedge clk) begin
        if (!xrst) begin
            busy_cnt = 0;
            prev_ack = 1'b0;
            last_out = '0;
        end else begin
            if (busy) begin
                busy_cnt++;
                if (busy_cnt == 1) check("hold_prev", 64'(outputs), 64'(last_out));
                check("w_addr_calc", 64'(w_addr), (busy_cnt <= TOT) ? 64'(busy_cnt - 1) : 64'd0);
            end else begin
                check("w_addr_idle", 64'(w_addr), 64'd0);
                if (busy_cnt != 0) begin
                    check("calc_len", 64'(busy_cnt), 64'(TOT + 1));
                    busy_cnt = 0;
                end
            end
            if (snd_ack && !prev_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(outputs), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(outputs), 64'(e));
                    last_out = e;
                end
            end
            prev_ack = snd_ack;
        end
    end

    // mode 0: normal, 1: disturb inputs/rcv_ack/snd_req during CALC, 2: snd_req held high early
    task automatic txn(input logic [N_IN-1:0] x, input logic [N_OUT-1:0] exp, input int mode);
        int n;
        n = 0;
        while (!rcv_req && n < 100) begin @(negedge clk); n++; end
        if (!rcv_req) begin check("rcv_req_timeout", 64'(rcv_req), 64'd1); return; end
        inputs  = x;
        rcv_ack = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        rcv_ack = 1'b0;
        check("busy_entry", 64'(busy), 64'd1);
        if (mode == 2) snd_req = 1'b1;
        n = 0;
        while (busy && n < 4 * TOT) begin
            if (mode == 1) begin
                inputs  = N_IN'($urandom);
                rcv_ack = 1'($urandom);
                snd_req = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        rcv_ack = 1'b0;
        if (busy) begin check("calc_timeout", 64'(busy), 64'd0); return; end
        if (mode == 2) begin
            @(negedge clk);
            check("snd_next_cycle", 64'(snd_ack), 64'd1);
            snd_req = 1'b0;
            @(negedge clk);
        end else begin
            snd_req = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                check("ack_before_req", 64'(snd_ack), 64'd0);
                @(negedge clk);
            end
            snd_req = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!snd_ack && n < 10);
            check("snd_ack_seen", 64'(snd_ack), 64'd1);
            snd_req = 1'b0;
            @(negedge clk);
        end
    endtask

    logic [N_IN-1:0] xv;

    initial begin
        xrst    = 1'b0;
        inputs  = '0;
        rcv_ack = 1'b0;
        snd_req = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin wvec[j] = '0; thr_tab[j] = 1; end
        #1;
        check("rst_outputs", 64'(outputs), 64'd0);
        check("rst_rcv_req", 64'(rcv_req), 64'd1);
        check("rst_snd_ack", 64'(snd_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_w_addr", 64'(w_addr), 64'd0);
        repeat (2) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);

        // all-zero weights against all-ones inputs: no matches anywhere
        txn(8'hFF, 4'b0000, 0);

        for (int j = 0; j < N_OUT; j++) begin wvec[j] = 8'hA5; thr_tab[j] = 8; end
        txn(8'hA5, 4'b1111, 0);
        thr_tab[2] = 9;
        txn(8'hA5, 4'b1011, 0);

        for (int t = 0; t < 12; t++) begin
            randomize_tables();
            xv = N_IN'($urandom);
            txn(xv, golden(xv), (t % 3 == 2) ? 2 : 0);
        end

        randomize_tables();
        xv = N_IN'($urandom);
        txn(xv, golden(xv), 1);

        // abort mid-CALC with reset
        randomize_tables();
        inputs  = N_IN'($urandom);
        rcv_ack = 1'b1;
        @(negedge clk);
        rcv_ack = 1'b0;
        repeat (4) @(negedge clk);
        #2 xrst = 1'b0;
        #1;
        check("abort_outputs", 64'(outputs), 64'd0);
        check("abort_rcv_req", 64'(rcv_req), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_w_addr", 64'(w_addr), 64'd0);
        repeat (2) @(negedge clk);
        #2 xrst = 1'b1;
        @(negedge clk);
        xv = N_IN'($urandom);
        txn(xv, golden(xv), 0);

        // back-to-back with snd_req held high; the second vector must overwrite every bit
        randomize_tables();
        xv = N_IN'($urandom);
        txn(xv, golden(xv), 2);
        txn(~xv, golden(~xv), 2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bnn_dense_layer.md
BNN_DENSE_LAYER -- requirements
Module: bnn_dense_layer

Interface
REQ-001 SHALL have parameter N_IN, default 784, meaning input vector width in bits.
REQ-002 SHALL have parameter N_OUT, default 256, meaning neuron count and output width.
REQ-003 SHALL have parameter CHUNK, default 16, meaning input bits processed per cycle; N_IN mod CHUNK = 0 required; NCH = N_IN/CHUNK.
REQ-004 SHALL derive localparam CW = $clog2(N_IN+1), the accumulator/threshold width, and AW = $clog2(N_OUT*NCH), the weight address width.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 xrst  input  1  reset, asynchronous, active-low.
REQ-007 inputs  input  N_IN  binary activation vector.
REQ-008 rcv_ack  input  1  upstream acknowledge; inputs valid while high.
REQ-009 rcv_req  output  1  ready for a new vector.
REQ-010 w_addr  output  AW  weight ROM address = j*NCH + k (neuron j, chunk k).
REQ-011 w_data  input  CHUNK  weight chunk for the previous cycle's w_addr (1-cycle synchronous ROM).
REQ-012 thr_data  input  CW  unsigned threshold of the neuron addressed by the previous cycle's w_addr.
REQ-013 snd_req  input  1  downstream request.
REQ-014 snd_ack  output  1  result held for downstream.
REQ-015 outputs  output  N_OUT  result vector; bit j = neuron j.
REQ-016 busy  output  1  high in CALC.

Function
REQ-017 SHALL implement states IDLE, CALC, SND_WAIT, SND.
REQ-018 IDLE: rcv_req=1; on rcv_ack=1 SHALL latch inputs into an internal register and go to CALC next cycle.
REQ-019 rcv_req SHALL be 1 only in IDLE; snd_ack SHALL be 1 only in SND; busy SHALL be 1 only in CALC.
REQ-020 CALC SHALL issue w_addr 0,1,...,N_OUT*NCH-1 on consecutive cycles, one per cycle, no bubbles.
REQ-021 Cycle after each address: SHALL compute popcount(~(x_chunk ^ w_data)) (XNOR match count) over input bits [k*CHUNK +: CHUNK], and add it to a CW-bit accumulator.
REQ-022 Accumulator SHALL be cleared at the start of each neuron (k=0 data loads popcount directly, no add of the stale value).
REQ-023 On k=NCH-1 data, bit j SHALL be set to (acc_total >= thr_data), acc_total including that final chunk; registered into outputs[j] at the same clock edge.
REQ-024 Accumulator SHALL never overflow: max value N_IN fits CW bits.
REQ-025 CALC SHALL last exactly N_OUT*NCH+1 cycles; go to SND_WAIT the cycle after the final bit is written.
REQ-026 SND_WAIT: on snd_req=1 go to SND; SND: on snd_req=0 go to IDLE.
REQ-027 outputs SHALL be stable from CALC exit until the next CALC entry; bits not yet computed in a new CALC SHALL hold the previous vector's values.
REQ-028 rcv_ack outside IDLE and snd_req outside SND_WAIT/SND SHALL be ignored; latched inputs SHALL not change outside IDLE->CALC transition.
REQ-029 snd_req already high on SND_WAIT entry SHALL advance to SND next cycle.
REQ-030 w_addr SHALL be 0 outside CALC; w_data/thr_data SHALL be ignored outside CALC.
REQ-031 SHALL support NCH=1 and N_OUT=1 degenerate cases with identical timing formula.

Reset
REQ-032 xrst=0 SHALL asynchronously force IDLE, outputs=0, latched inputs=0, accumulator=0, counters=0, w_addr=0, rcv_req=1, snd_ack=0, busy=0.
REQ-033 Reset asserted mid-CALC SHALL abort the computation; after release the block SHALL accept a new vector with no residual state.

Verification
REQ-034 N_IN=8,N_OUT=4,CHUNK=4; inputs=8'hFF, all weights 0, all thr=1 -> outputs=4'b0000, snd_ack after snd_req, CALC length 9 cycles.
REQ-035 Same params; inputs=8'hA5, neuron j weights=8'hA5, thr=8 -> outputs=4'b1111; change thr of neuron 2 to 9 (unreachable) -> outputs=4'b1011.
REQ-036 Defaults (784/256/16) with random weights/thresholds -> outputs match golden model; busy high exactly 12545 cycles; w_addr sweeps 0..12543.
REQ-037 rcv_ack pulsed and inputs changed during CALC; snd_req toggled during CALC -> no state change, result equals first vector's golden result.
REQ-038 xrst pulsed low at CALC cycle 100 -> all outputs 0 immediately, rcv_req=1; next transaction produces correct golden result.
REQ-039 Back-to-back transactions with snd_req held high before SND_WAIT -> SND reached one cycle after CALC exit; second vector's bits overwrite first correctly.
